// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder used as the serial adder's arithmetic slice.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one operand bit per clock through a single full-adder cell.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | processing bit cnt of the captured operands
// DONE  | result valid, done pulses for this one cycle
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             bit_a;
    logic             bit_b;
    logic             fa_sum;
    logic             fa_cout;
    logic             carry_init;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_r;

    // Subtraction as a + ~b + 1: invert b bit-by-bit and seed the carry with 1.
    assign bit_b      = b_r[cnt] ^ sub_r;
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign bit_b      = b_r[cnt];
    assign carry_init = cin;
`endif

    assign bit_a = a_r[cnt];

    full_adder_cell u_fa (
        .a    (bit_a),
        .b    (bit_b),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        cnt   <= '0;
                        carry <= carry_init;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_r <= sub;
`endif
                    end
                end
                RUN: begin
                    sum[cnt] <= fa_sum;
                    carry    <= fa_cout;
                    cnt      <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Subtract vectors are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic accept(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        wait_idle();
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic [7:0] es, input logic ec);
        int  k;
        bit  seen;
        accept(va, vb, vc);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        k    = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(k), 64'd8);
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_sum_hold"}, 64'(sum), 64'(es));
    endtask

    logic [7:0] ha [4];
    logic [7:0] hb [4];
    logic [7:0] hs [4];
    logic       hc [4];
    logic       hco[4];

    initial begin
        int dcount;
        int nd;
        int cyc;
        int last;

        ha[0] = 8'h11; hb[0] = 8'h22; hc[0] = 1'b0; hs[0] = 8'h33; hco[0] = 1'b0;
        ha[1] = 8'hC8; hb[1] = 8'h64; hc[1] = 1'b1; hs[1] = 8'h2D; hco[1] = 1'b1;
        ha[2] = 8'h01; hb[2] = 8'hFE; hc[2] = 1'b1; hs[2] = 8'h00; hco[2] = 1'b1;
        ha[3] = 8'h55; hb[3] = 8'h55; hc[3] = 1'b0; hs[3] = 8'hAA; hco[3] = 1'b0;

        rst   = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;

        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        run_op("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        run_op("7f_01c", 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0);
        run_op("f0_0f", 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0);

        // Starts during RUN with different operands must be ignored
        accept(8'h3C, 8'h0F, 1'b0);
        a      = 8'hFF;
        b      = 8'hFF;
        cin    = 1'b1;
        dcount = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                chk("ign_sum", 64'(sum), 64'h4B);
                chk("ign_cout", 64'(cout), 64'd0);
            end
            start = (i == 2 || i == 5);
        end
        start = 1'b0;
        chk("ign_done_count", 64'(dcount), 64'd1);

        // Reset in the middle of RUN aborts without a done pulse
        accept(8'hFF, 8'hFF, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);
        run_op("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // start held high: one operation every WIDTH+2 cycles
        wait_idle();
        a     = ha[0];
        b     = hb[0];
        cin   = hc[0];
        start = 1'b1;
        nd    = 0;
        cyc   = 0;
        last  = 0;
        while (nd < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                chk("held_sum", 64'(sum), 64'(hs[nd]));
                chk("held_cout", 64'(cout), 64'(hco[nd]));
                if (nd > 0) chk("held_period", 64'(cyc - last), 64'd10);
                last = cyc;
                nd++;
                if (nd < 4) begin
                    a   = ha[nd];
                    b   = hb[nd];
                    cin = hc[nd];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("held_count", 64'(nd), 64'd4);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op("sub_5_7", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
        run_op("sub_7_5", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
        sub = 1'b0;
        run_op("add_after_sub", 8'h07, 8'h05, 1'b0, 8'h0C, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 The block SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum  output  WIDTH  registered result.
REQ-011 The block SHALL have port cout  output  1  registered carry-out of the MSB.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at a rising edge SHALL capture a, b and cin, clear the bit counter and enter RUN.
REQ-014 In RUN, each rising edge SHALL process bit i, LSB first (i=0..WIDTH-1): sum[i] = a[i]^b[i]^c; c = majority(a[i],b[i],c).
REQ-015 On the edge that processes bit WIDTH-1, the FSM SHALL enter DONE and load cout with the final carry.
REQ-016 done SHALL be high for exactly the one cycle the FSM is in DONE; the FSM SHALL then return to IDLE.
REQ-017 Latency: start accepted at edge t0 SHALL give done high between edges t0+WIDTH and t0+WIDTH+1.
REQ-018 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-019 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change mid-operation.
REQ-020 sum and cout SHALL hold their last final values in IDLE until the next accepted start.
REQ-021 sum and cout SHALL NOT be read as valid while busy=1; partial bits may be visible.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide; its wrap-around SHALL have no functional effect because the exit is decided at count WIDTH-1.
REQ-023 Back-to-back: start held high SHALL be accepted again on the first edge in IDLE after DONE, giving one operation per WIDTH+2 cycles.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE and busy=0, done=0, sum=0, cout=0, with the counter, internal carry and operand registers cleared.
REQ-025 rst asserted mid-operation SHALL abort the addition with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN SHALL be the only compile-time option.
REQ-027 With SERIAL_ADDER_SUB_EN defined, an input port sub (1 bit, captured with start) SHALL exist; sub=1 SHALL compute a + ~b + 1, ignoring cin; cout=0 SHALL mean borrow.
REQ-028 With SERIAL_ADDER_SUB_EN undefined, the sub port and its logic SHALL be absent and the block SHALL only add.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-030 Per-bit arithmetic SHALL be a sub-module full_adder_cell (a, b, cin -> sum, cout), combinational, instantiated once.

Verification (WIDTH=8)
REQ-031 a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, done exactly 8 edges after the accepting edge, single cycle.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-033 start pulsed at cycles 2 and 5 of a run with different operands -> result matches first operands; only one done.
REQ-034 rst asserted in cycle 4 of RUN -> busy=0, sum=0, no done; next start (0x12+0x34) -> sum=0x46, cout=0.
REQ-035 start held high continuously -> done pulses every 10 cycles, each result correct.
REQ-036 With SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
